// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch front end and its controller:
// next-PC select encoding and the fetch FSM state.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PcSel_PP4 = 2'b00,
        PcSel_OFS = 2'b01,
        PcSel_IND = 2'b10
    } PcSel;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        VALID = 2'b10,
        FAULT = 2'b11
    } FetchState;

    localparam int unsigned InstBytes = 4;

endpackage

// File: rtl/instruction_fetch_unit_pc_next_calc.sv
// Next-PC target selection and misalignment detection; purely combinational.
module pc_next_calc
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            pcSel,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic [ADDR_WIDTH-1:0] regBase,
    output logic [ADDR_WIDTH-1:0] target,
    output logic                  misaligned
);

    localparam logic [ADDR_WIDTH-1:0] ClearBit0 = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    // Select 2'b11 is unused by the controller and falls back to PC+4.
    always_comb begin
        target = pc + ADDR_WIDTH'(InstBytes);
        case (pcSel)
            PcSel_OFS: target = pc + offset;
            PcSel_IND: target = (regBase + offset) & ClearBit0;
            default:   ;
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end: owns the PC, fetches one word per req/ack handshake
// and holds it until the controller accepts; misaligned targets halt the unit.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic                  o_MemReq,
    input  logic                  i_MemAck,
    input  logic [DATA_WIDTH-1:0] i_MemRdData,
    output logic [DATA_WIDTH-1:0] o_Inst,
    output logic                  o_InstValid,
    input  logic                  i_InstAccept,
    input  logic [1:0]            i_PCNextSel,
    input  logic [ADDR_WIDTH-1:0] i_Offset,
    input  logic [ADDR_WIDTH-1:0] i_RegBase,
    output logic [ADDR_WIDTH-1:0] o_PC,
    output logic [ADDR_WIDTH-1:0] o_PCPlus4,
    output logic                  o_Fault
);

    FetchState             state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  misaligned;

    pc_next_calc #(.ADDR_WIDTH(ADDR_WIDTH)) uNextPc (
        .pc         (pc),
        .pcSel      (i_PCNextSel),
        .offset     (i_Offset),
        .regBase    (i_RegBase),
        .target     (target),
        .misaligned (misaligned)
    );

    // All handshake outputs are registered alongside the state so they change
    // only on the transition that implies them.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            o_MemReq    <= 1'b0;
            o_InstValid <= 1'b0;
            o_Inst      <= '0;
            o_Fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    o_MemReq <= 1'b1;
                end
                FETCH: begin
                    if (i_MemAck) begin
                        o_Inst      <= i_MemRdData;
                        o_MemReq    <= 1'b0;
                        o_InstValid <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (i_InstAccept) begin
                        o_InstValid <= 1'b0;
                        if (misaligned) begin
                            o_Fault <= 1'b1;
                            state   <= FAULT;
                        end else begin
                            pc       <= target;
                            o_MemReq <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_MemAddr = pc;
    assign o_PC      = pc;
    assign o_PCPlus4 = pc + ADDR_WIDTH'(InstBytes);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a task-driven memory pushes each
// returned word as an expectation, popped when o_InstValid appears.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] memAddr;
    logic        memReq;
    logic        memAck = 1'b0;
    logic [31:0] memRdData = '0;
    logic [31:0] inst;
    logic        instValid;
    logic        instAccept = 1'b0;
    logic [1:0]  pcSel = 2'b00;
    logic [31:0] offset = '0;
    logic [31:0] regBase = '0;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ExpT;

    ExpT sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  validCyc = 0;

    instruction_fetch_unit dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .o_MemAddr    (memAddr),
        .o_MemReq     (memReq),
        .i_MemAck     (memAck),
        .i_MemRdData  (memRdData),
        .o_Inst       (inst),
        .o_InstValid  (instValid),
        .i_InstAccept (instAccept),
        .i_PCNextSel  (pcSel),
        .i_Offset     (offset),
        .i_RegBase    (regBase),
        .o_PC         (pcOut),
        .o_PCPlus4    (pcPlus4),
        .o_Fault      (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic doReset(input int n);
        rst = 1'b1; memAck = 1'b0; instAccept = 1'b0;
        repeat (n) @(negedge clk);
        tests++;
        if (memReq !== 1'b0 || instValid !== 1'b0 || inst !== 32'h0 || fault !== 1'b0 ||
            pcOut !== 32'h0 || pcPlus4 !== 32'h4 || memAddr !== 32'h0) begin
            fails++;
            $display("FAIL reset_values got req=%b vld=%b inst=%h flt=%b pc=%h pc4=%h addr=%h exp 0 0 0 0 0 4 0",
                     memReq, instValid, inst, fault, pcOut, pcPlus4, memAddr);
        end
        rst = 1'b0;
    endtask

    // Answer the next fetch after `waits` stall cycles, then check the result.
    task automatic serveFetch(input int waits, input logic [31:0] expAddr);
        int guard = 0;
        logic [31:0] addr;
        ExpT e;
        while (memReq !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (memReq !== 1'b1) begin
            fails++;
            $display("FAIL fetch_req_timeout got req=%b exp 1 for addr %h", memReq, expAddr);
            return;
        end
        tests++;
        if (memAddr !== expAddr) begin
            fails++;
            $display("FAIL fetch_addr got %h exp %h", memAddr, expAddr);
        end
        addr = memAddr;
        for (int w = 0; w < waits; w++) begin
            memAck = 1'b0;
            @(negedge clk);
            tests++;
            if (memReq !== 1'b1 || memAddr !== addr || instValid !== 1'b0) begin
                fails++;
                $display("FAIL wait_stable got req=%b addr=%h vld=%b exp 1 %h 0", memReq, memAddr, instValid, addr);
            end
        end
        memAck = 1'b1;
        memRdData = memWord(addr);
        sb.push_back('{pc: expAddr, inst: memWord(expAddr)});
        @(negedge clk);
        memAck = 1'b0;
        memRdData = 32'hDEAD_BEEF;
        e = sb.pop_front();
        validCyc = cyc;
        tests++;
        if (instValid !== 1'b1 || memReq !== 1'b0 || inst !== e.inst || pcOut !== e.pc ||
            pcPlus4 !== e.pc + 32'd4) begin
            fails++;
            $display("FAIL fetch_result got vld=%b req=%b inst=%h pc=%h pc4=%h exp 1 0 %h %h %h",
                     instValid, memReq, inst, pcOut, pcPlus4, e.inst, e.pc, e.pc + 32'd4);
        end
    endtask

    task automatic acceptWith(input logic [1:0] sel, input logic [31:0] ofs, input logic [31:0] base);
        pcSel = sel; offset = ofs; regBase = base; instAccept = 1'b1;
        @(negedge clk);
        instAccept = 1'b0;
    endtask

    task automatic checkFaulted(input logic [31:0] expPc, input logic [31:0] expInst);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                memAck = 1'b1;
                memRdData = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            memAck = 1'b0;
            tests++;
            if (fault !== 1'b1 || memReq !== 1'b0 || instValid !== 1'b0 || pcOut !== expPc || inst !== expInst) begin
                fails++;
                $display("FAIL fault_state got flt=%b req=%b vld=%b pc=%h inst=%h exp 1 0 0 %h %h",
                         fault, memReq, instValid, pcOut, inst, expPc, expInst);
            end
        end
    endtask

    task automatic test_reset();
        doReset(3);
    endtask

    task automatic test_seq_zero_wait();
        int prev;
        serveFetch(0, 32'h0);
        prev = validCyc;
        for (int i = 1; i < 3; i++) begin
            acceptWith(2'b00, 32'h0, 32'h0);
            serveFetch(0, 32'(i * 4));
            tests++;
            if (validCyc - prev != 2) begin
                fails++;
                $display("FAIL zero_wait_rate got %0d cycles exp 2", validCyc - prev);
            end
            prev = validCyc;
        end
    endtask

    task automatic test_seq_wait3();
        doReset(2);
        serveFetch(3, 32'h0);
        acceptWith(2'b00, 32'h0, 32'h0);
        serveFetch(3, 32'h4);
        acceptWith(2'b11, 32'h40, 32'h0);
        serveFetch(3, 32'h8);
    endtask

    task automatic test_branch_hold();
        acceptWith(2'b01, 32'h18, 32'h0);
        serveFetch(1, 32'h20);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                memAck = 1'b1;
                memRdData = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            memAck = 1'b0;
            tests++;
            if (instValid !== 1'b1 || inst !== memWord(32'h20) || pcOut !== 32'h20 || memReq !== 1'b0) begin
                fails++;
                $display("FAIL hold_valid got vld=%b inst=%h pc=%h req=%b exp 1 %h 20 0",
                         instValid, inst, pcOut, memReq, memWord(32'h20));
            end
        end
        acceptWith(2'b01, 32'hFFFF_FFF8, 32'h0);
        serveFetch(0, 32'h18);
        acceptWith(2'b01, 32'hE8, 32'h0);
        serveFetch(0, 32'h100);
    endtask

    task automatic test_jalr();
        acceptWith(2'b10, 32'h4, 32'h2001);
        serveFetch(2, 32'h2004);
    endtask

    task automatic test_fault_jalr();
        acceptWith(2'b10, 32'h0, 32'h2002);
        checkFaulted(32'h2004, memWord(32'h2004));
        doReset(2);
        serveFetch(0, 32'h0);
    endtask

    task automatic test_fault_branch();
        acceptWith(2'b01, 32'h6, 32'h0);
        checkFaulted(32'h0, memWord(32'h0));
    endtask

    task automatic test_reset_mid_fetch();
        int guard = 0;
        doReset(2);
        while (memReq !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (memReq !== 1'b0) begin
            fails++;
            $display("FAIL reset_drops_req got req=%b exp 0", memReq);
        end
        @(negedge clk);
        rst = 1'b0;
        serveFetch(3, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_seq_zero_wait();
        test_seq_wait3();
        test_branch_hold();
        test_jalr();
        test_fault_jalr();
        test_fault_branch();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the single-issue RV32I core. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and holds each fetched instruction for the datapath controller.
- It consumes the controller's 2-bit next-PC select plus branch/jump operands on handshake acceptance, then computes the next fetch address.
- It detects misaligned fetch targets and halts with a sticky fault.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction word width; must be 32.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
- i_Clock  in  1  clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- o_MemAddr  out  ADDR_WIDTH  instruction memory byte address; always word aligned.
- o_MemReq  out  1  read request; held until ack.
- i_MemAck  in  1  read data valid this cycle; sampled only while o_MemReq=1.
- i_MemRdData  in  DATA_WIDTH  read data, valid with i_MemAck.
- o_Inst  out  DATA_WIDTH  registered instruction for the controller.
- o_InstValid  out  1  o_Inst holds a fetched, unconsumed instruction.
- i_InstAccept  in  1  consumer takes o_Inst this cycle; ignored unless o_InstValid=1.
- i_PCNextSel  in  2  00 PC+4, 01 PC+offset, 10 (rs1+offset)&~1, 11 treated as 00.
- i_Offset  in  ADDR_WIDTH  sign-extended branch/jump immediate.
- i_RegBase  in  ADDR_WIDTH  rs1 value for indirect jumps.
- o_PC  out  ADDR_WIDTH  address of the instruction in o_Inst.
- o_PCPlus4  out  ADDR_WIDTH  o_PC+4, used for the link-register write.
- o_Fault  out  1  sticky misaligned-target fault.

Behaviour:
- States: IDLE, FETCH, VALID, FAULT.
- Reset, taking priority over everything: state=IDLE, PC=RESET_PC, o_MemReq=0, o_InstValid=0, o_Inst=0, o_Fault=0. o_PC=RESET_PC and o_PCPlus4=RESET_PC+4.
- IDLE: one cycle, then FETCH.
- FETCH:
  - o_MemReq=1 and o_MemAddr=PC; the address is stable until ack.
  - On i_MemAck=1: o_Inst<=i_MemRdData, state->VALID. Ack in the first FETCH cycle is legal (zero wait).
- VALID:
  - o_InstValid=1 and o_MemReq=0; o_Inst and o_PC are held until i_InstAccept.
  - On accept, the target is computed in ADDR_WIDTH modulo arithmetic; wrap-around is silent, not a fault.
    - 00 or 11: PC+4.
    - 01: PC+i_Offset.
    - 10: (i_RegBase+i_Offset) with bit0 cleared.
  - If target[1:0]==0: PC<=target, state->FETCH.
  - Otherwise: state->FAULT and PC is unchanged.
- FAULT: o_Fault=1, o_MemReq=0, o_InstValid=0. Only reset exits.
- Throughput: 2 cycles per instruction with a zero-wait memory; latency from accept to the next o_InstValid is 2+wait cycles.
- Reset mid-FETCH: the request is dropped immediately. Memory shares the reset and must not ack a dropped request.
- i_InstAccept while not VALID: ignored.
- i_MemAck while o_MemReq=0: ignored; o_Inst is unchanged.

Decomposition:
- Types package:
  - PcSel enum (PcSel_PP4=2'b00, PcSel_OFS=2'b01, PcSel_IND=2'b10). The controller's local pcPP4/pcOFS/pcIND values move here and both blocks import it.
  - FetchState enum (IDLE, FETCH, VALID, FAULT).
- Sub-module pc_next_calc: combinational target adder/mux plus misalignment flag. Inputs are PC, select, offset and base; outputs are target and misaligned.

Test Plan:
- Reset/boot: hold i_Reset 3 cycles, release → o_MemReq rises 2 cycles later with o_MemAddr=0x0. During reset all outputs are at reset values and o_PCPlus4=0x4.
- Sequential fetch, zero-wait then 3-wait memory: accept each with sel=00 → addresses 0x0,0x4,0x8. The zero-wait case shows o_InstValid every 2nd cycle. In the 3-wait case o_MemAddr stays stable across the wait cycles and o_Inst equals the memory word.
- Branch: at PC=0x20 accept with sel=01, offset=-8 (0xFFFF_FFF8) → next o_MemAddr=0x18. Delay accept 4 cycles → o_Inst and o_PC are held unchanged.
- JALR: at PC=0x100 accept sel=10, base=0x2001, offset=0x4 → target 0x2004 (bit0 cleared).
- Misaligned targets → o_Fault=1, no further o_MemReq:
  - JALR with base=0x2002, offset=0: target 0x2002.
  - Branch with offset=0x6.
  - After a 2-cycle reset, fetch restarts at RESET_PC.
- Reset mid-fetch and stray handshakes:
  - Assert reset during a 3-wait FETCH → o_MemReq=0 in the next cycle; after release, fetch restarts at 0x0.
  - A spurious i_MemAck while idle or in VALID leaves o_Inst unchanged.
